// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : shift_arbiter (with local barrel_shift_right)
//  Description : Round-robin arbiter that shares one right-only barrel
//                shifter between requesters A and B. Logical left shift is
//                built with bit reversal around the shifter, and rotate right
//                uses a second reversed pass.
//  Revision    : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
// barrel_shift_right : 32-bit logical right shifter, five log stages
// ----------------------------------------------------------------------------
module barrel_shift_right (
   input  logic [31:0] din,
   input  logic [4:0]  amt,
   output logic [31:0] dout
);

   logic [5:0][31:0] w_stage;

   assign w_stage[0] = din;

   // Each stage conditionally shifts by 2**k when amount bit k is set.
   generate
      for (genvar k = 0; k < 5; k++) begin : g_stage
         localparam int SHIFT = 1 << k;
         assign w_stage[k+1] = amt[k] ? (w_stage[k] >> SHIFT) : w_stage[k];
      end
   endgenerate

   assign dout = w_stage[5];

endmodule

// ----------------------------------------------------------------------------
// shift_arbiter : top level
// ----------------------------------------------------------------------------
module shift_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        a_req,
   input  logic [1:0]  a_op,
   input  logic [31:0] a_data,
   input  logic [4:0]  a_amt,
   output logic        a_ack,
   output logic        a_done,
   input  logic        b_req,
   input  logic [1:0]  b_op,
   input  logic [31:0] b_data,
   input  logic [4:0]  b_amt,
   output logic        b_ack,
   output logic        b_done,
   output logic [31:0] result,
   output logic        busy
);

   localparam logic [1:0] C_OP_SRL = 2'b00;
   localparam logic [1:0] C_OP_SLL = 2'b01;
   localparam logic [1:0] C_OP_ROR = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS1 = 2'd1,
      PASS2 = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_n;

   logic [1:0]  r_op;
   logic [31:0] r_data;
   logic [4:0]  r_amt;
   logic        r_owner;      // 0 = A, 1 = B
   logic        r_pri;        // 0 = A preferred, 1 = B preferred
   logic [31:0] r_acc;
   logic [31:0] r_result;
   logic        r_a_ack;
   logic        r_b_ack;
   logic        r_a_done;
   logic        r_b_done;

   logic        w_grant;
   logic        w_grant_b;
   logic        w_finish;
   logic        w_to_pass2;
   logic [31:0] w_result_n;
   logic [31:0] w_sh_in;
   logic [4:0]  w_sh_amt;
   logic [31:0] w_sh_out;

   // 32-bit bit reversal: bit i moves to bit 31-i.
   function automatic logic [31:0] rev(input logic [31:0] x);
      logic [31:0] y;
      y = '0;
      for (int i = 0; i < 32; i++) begin
         y[31-i] = x[i];
      end
      return y;
   endfunction

   // Shifter operands come only from the latched operands and the state,
   // never directly from requester ports.
   always_comb begin
      w_sh_in  = r_data;
      w_sh_amt = r_amt;
      case (r_state)
         PASS1: begin
            w_sh_in  = (r_op == C_OP_SLL) ? rev(r_data) : r_data;
            w_sh_amt = r_amt;
         end
         PASS2: begin
            // Second rotate pass: left shift by (32 - amt) via reversal.
            w_sh_in  = rev(r_data);
            w_sh_amt = ~r_amt + 5'd1;
         end
         default: begin
            w_sh_in  = r_data;
            w_sh_amt = r_amt;
         end
      endcase
   end

   barrel_shift_right u_shifter (
      .din  (w_sh_in),
      .amt  (w_sh_amt),
      .dout (w_sh_out)
   );

   // Next-state, arbitration and result selection.
   always_comb begin
      w_state_n  = r_state;
      w_grant    = 1'b0;
      w_grant_b  = 1'b0;
      w_finish   = 1'b0;
      w_to_pass2 = 1'b0;
      w_result_n = r_result;
      case (r_state)
         IDLE: begin
            if (a_req && b_req) begin
               w_grant   = 1'b1;
               w_grant_b = r_pri;
            end else if (a_req) begin
               w_grant   = 1'b1;
               w_grant_b = 1'b0;
            end else if (b_req) begin
               w_grant   = 1'b1;
               w_grant_b = 1'b1;
            end
            if (w_grant) begin
               w_state_n = PASS1;
            end
         end
         PASS1: begin
            if ((r_op == C_OP_ROR) && (r_amt != 5'd0)) begin
               w_to_pass2 = 1'b1;
               w_state_n  = PASS2;
            end else begin
               w_finish   = 1'b1;
               w_state_n  = IDLE;
               w_result_n = (r_op == C_OP_SLL) ? rev(w_sh_out) : w_sh_out;
            end
         end
         PASS2: begin
            w_finish   = 1'b1;
            w_state_n  = IDLE;
            w_result_n = r_acc | rev(w_sh_out);
         end
         default: begin
            w_state_n = IDLE;
         end
      endcase
   end

   // State, operand capture, handshake pulses and result register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_op     <= C_OP_SRL;
         r_data   <= '0;
         r_amt    <= '0;
         r_owner  <= 1'b0;
         r_pri    <= 1'b0;
         r_acc    <= '0;
         r_result <= '0;
         r_a_ack  <= 1'b0;
         r_b_ack  <= 1'b0;
         r_a_done <= 1'b0;
         r_b_done <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_a_ack  <= w_grant & ~w_grant_b;
         r_b_ack  <= w_grant &  w_grant_b;
         r_a_done <= w_finish & ~r_owner;
         r_b_done <= w_finish &  r_owner;
         if (w_grant) begin
            r_owner <= w_grant_b;
            r_op    <= w_grant_b ? b_op   : a_op;
            r_data  <= w_grant_b ? b_data : a_data;
            r_amt   <= w_grant_b ? b_amt  : a_amt;
         end
         if (w_to_pass2) begin
            r_acc <= w_sh_out;
         end
         if (w_finish) begin
            r_result <= w_result_n;
            r_pri    <= ~r_owner;
         end
      end
   end

   assign a_ack  = r_a_ack;
   assign b_ack  = r_b_ack;
   assign a_done = r_a_done;
   assign b_done = r_b_done;
   assign result = r_result;
   assign busy   = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_arbiter
//  Description : Self-checking bench for shift_arbiter: directed cases plus
//                randomized operations against a behavioural shift model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        a_req = 1'b0, b_req = 1'b0;
   logic [1:0]  a_op = '0, b_op = '0;
   logic [31:0] a_data = '0, b_data = '0;
   logic [4:0]  a_amt = '0, b_amt = '0;
   logic        a_ack, a_done, b_ack, b_done, busy;
   logic [31:0] result;

   int tests = 0;
   int fails = 0;

   shift_arbiter dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_op(a_op), .a_data(a_data), .a_amt(a_amt),
      .a_ack(a_ack), .a_done(a_done),
      .b_req(b_req), .b_op(b_op), .b_data(b_data), .b_amt(b_amt),
      .b_ack(b_ack), .b_done(b_done),
      .result(result), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: arithmetic definition of each operation.
   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d, input logic [4:0] amt);
      logic [63:0] dd;
      dd = {d, d} >> amt;
      case (op)
         2'b01:   return d << amt;
         2'b10:   return dd[31:0];
         default: return d >> amt;
      endcase
   endfunction

   function automatic int model_lat(input logic [1:0] op, input logic [4:0] amt);
      return (op == 2'b10 && amt != 5'd0) ? 2 : 1;
   endfunction

   // Expected {a,b} vector for a pulse belonging to requester who (0=A).
   function automatic logic [31:0] vec(input bit who);
      return who ? 32'd1 : 32'd2;
   endfunction

   task automatic set_req(input bit who, input logic v, input logic [1:0] op,
                          input logic [31:0] d, input logic [4:0] amt);
      if (!who) begin a_req = v; a_op = op; a_data = d; a_amt = amt; end
      else      begin b_req = v; b_op = op; b_data = d; b_amt = amt; end
   endtask

   // One full transaction from an idle FSM: ack on the first edge, done
   // after the modelled latency, result compared with the model.
   task automatic do_op(input bit who, input logic [1:0] op, input logic [31:0] d, input logic [4:0] amt);
      int n;
      bit got;
      @(negedge clk);
      set_req(who, 1'b1, op, d, amt);
      @(posedge clk); #1;
      check("ack_vec", {30'd0, a_ack, b_ack}, vec(who));
      check("busy_after_grant", {31'd0, busy}, 32'd1);
      set_req(who, 1'b0, op, d, amt);
      n = 0; got = 1'b0;
      for (int i = 1; i <= 5 && !got; i++) begin
         @(posedge clk); #1;
         if (a_done || b_done) begin
            got = 1'b1;
            n = i;
            check("done_vec", {30'd0, a_done, b_done}, vec(who));
            check("ack_clear_at_done", {30'd0, a_ack, b_ack}, 32'd0);
         end
      end
      check("latency", n, model_lat(op, amt));
      check("result", result, model(op, d, amt));
   endtask

   initial begin
      bit          who, d, got;
      bit          exp_who;
      logic [1:0]  op;
      logic [31:0] data;
      logic [4:0]  amt;

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      check("rst_result", result, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_pulses", {28'd0, a_ack, b_ack, a_done, b_done}, 32'd0);

      // Directed operations.
      do_op(1'b0, 2'b00, 32'h8000_0001, 5'd4);
      do_op(1'b1, 2'b01, 32'h0000_00FF, 5'd8);
      do_op(1'b1, 2'b01, 32'h0000_0001, 5'd31);
      do_op(1'b0, 2'b10, 32'h1234_5678, 5'd8);
      check("ror8_value", result, 32'h7812_3456);
      do_op(1'b0, 2'b10, 32'h1234_5678, 5'd0);
      do_op(1'b0, 2'b10, 32'h0000_0001, 5'd31);
      check("ror31_value", result, 32'h0000_0002);
      // Only B requesting: back-to-back grants.
      do_op(1'b1, 2'b00, 32'hF000_000F, 5'd1);
      do_op(1'b1, 2'b01, 32'hF000_000F, 5'd3);

      // Op 11 on A, with B raising its request while busy.
      @(negedge clk);
      set_req(1'b0, 1'b1, 2'b11, 32'hFFFF_0000, 5'd16);
      @(posedge clk); #1;
      check("op11_ack", {30'd0, a_ack, b_ack}, 32'd2);
      set_req(1'b0, 1'b0, 2'b11, 32'hFFFF_0000, 5'd16);
      set_req(1'b1, 1'b1, 2'b10, 32'hA5A5_0000, 5'd4);
      @(posedge clk); #1;
      check("op11_done", {30'd0, a_done, b_done}, 32'd2);
      check("busy_req_not_acked", {31'd0, b_ack}, 32'd0);
      check("op11_result", result, 32'h0000_FFFF);
      @(posedge clk); #1;
      check("late_b_ack", {30'd0, a_ack, b_ack}, 32'd1);
      set_req(1'b1, 1'b0, 2'b10, 32'hA5A5_0000, 5'd4);
      repeat (2) @(posedge clk);
      #1;
      check("late_b_done", {30'd0, a_done, b_done}, 32'd1);
      check("late_b_result", result, model(2'b10, 32'hA5A5_0000, 5'd4));

      // Reset during PASS2 of a rotate.
      @(negedge clk);
      set_req(1'b0, 1'b1, 2'b10, 32'h1234_5678, 5'd8);
      @(posedge clk); #1;
      set_req(1'b0, 1'b0, 2'b10, 32'h1234_5678, 5'd8);
      @(posedge clk); #1;          // now in PASS2
      check("pass2_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_done", {30'd0, a_done, b_done}, 32'd0);
      check("rst_mid_result", result, 32'd0);
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      @(negedge clk); reset = 1'b0;
      do_op(1'b0, 2'b10, 32'hDEAD_BEEF, 5'd12);

      // Round robin after reset: both request continuously.
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      set_req(1'b0, 1'b1, 2'b00, 32'h0000_F000, 5'd4);
      set_req(1'b1, 1'b1, 2'b01, 32'h0000_000F, 5'd4);
      exp_who = 1'b0;
      for (int g = 0; g < 4; g++) begin
         got = 1'b0; who = 1'b0;
         for (int i = 0; i < 6 && !got; i++) begin
            @(posedge clk); #1;
            if (a_ack || b_ack) begin got = 1'b1; who = b_ack; end
         end
         check("rr_grant_seen", {31'd0, got}, 32'd1);
         check("rr_grant_owner", {31'd0, who}, {31'd0, exp_who});
         if (!who) a_req = 1'b0; else b_req = 1'b0;
         d = 1'b0;
         for (int i = 0; i < 6 && !d; i++) begin
            @(posedge clk); #1;
            if (who ? b_done : a_done) d = 1'b1;
         end
         check("rr_done_seen", {31'd0, d}, 32'd1);
         check("rr_result", result, who ? 32'h0000_00F0 : 32'h0000_0F00);
         if (g < 3) begin
            if (!who) a_req = 1'b1; else b_req = 1'b1;
         end else begin
            a_req = 1'b0; b_req = 1'b0;
         end
         exp_who = ~exp_who;
      end
      repeat (3) @(posedge clk);

      // Randomized single-requester operations.
      for (int t = 0; t < 24; t++) begin
         who  = 1'($urandom_range(0, 1));
         op   = 2'($urandom_range(0, 3));
         data = $urandom;
         amt  = 5'($urandom_range(0, 31));
         do_op(who, op, data, amt);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
